// File: rtl/vram_fetch_arbiter_if.sv
// Signal bundle between the VRAM fetch arbiter and its surroundings.
// The arbiter is the slave side; the frame timing, CPU and RAM model form the master side.
interface vram_fetch_arbiter_if;
   // Frame timing and display mode
   logic        FSn;
   logic        HSn;
   logic        DA0;
   logic        AnG;
   logic [2:0]  GM;
   logic [15:0] VidBase;
   // CPU port: CpuReq is a level held until the one-cycle CpuAck pulse;
   // the requester drops it on the cycle after CpuAck, and a request still
   // high once the arbiter is idle again starts a new transaction.
   logic        CpuReq;
   logic        CpuWe;
   logic [15:0] CpuAddr;
   logic [7:0]  CpuWData;
   logic        CpuAck;
   logic [7:0]  CpuRData;
   // Synchronous single-port RAM
   logic        RamCs;
   logic        RamWe;
   logic [15:0] RamAddr;
   logic [7:0]  RamWData;
   logic [7:0]  RamRData;
   // Video data out
   logic [7:0]  VData;
   logic        VValid;
   logic        Overrun;
   // Current arbiter FSM state
   logic [2:0]  DbgState;

   modport slave (
      input  FSn, HSn, DA0, AnG, GM, VidBase,
      input  CpuReq, CpuWe, CpuAddr, CpuWData,
      output CpuAck, CpuRData,
      output RamCs, RamWe, RamAddr, RamWData,
      input  RamRData,
      output VData, VValid, Overrun, DbgState
   );

   modport master (
      output FSn, HSn, DA0, AnG, GM, VidBase,
      output CpuReq, CpuWe, CpuAddr, CpuWData,
      input  CpuAck, CpuRData,
      input  RamCs, RamWe, RamAddr, RamWData,
      output RamRData,
      input  VData, VValid, Overrun, DbgState
   );
endinterface

// File: rtl/vram_fetch_arbiter.sv
// Shares one synchronous VRAM port between the VDG display fetch and a host CPU.
// Display addresses are regenerated from FSn/HSn/DA0 edges and the latched display mode.
module vram_fetch_arbiter (
   input  logic Clk,
   input  logic Rstn,
   vram_fetch_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      VID_RD  = 3'd1,
      VID_CAP = 3'd2,
      CPU_RD  = 3'd3,
      CPU_CAP = 3'd4,
      CPU_WR  = 3'd5
   } state_t;

   state_t      state_q, state_d;

   logic        fs_s_q, fs_p_q, hs_s_q, hs_p_q, da_s_q, da_p_q;
   logic [5:0]  bpr_q, bpr_d;
   logic [3:0]  rep_q, rep_d;
   logic [15:0] row_base_q, row_base_d;
   logic [15:0] vid_addr_q, vid_addr_d;
   logic [3:0]  line_cnt_q, line_cnt_d;
   logic [5:0]  byte_cnt_q, byte_cnt_d;
   logic        vid_pend_q, vid_pend_d;
   logic        overrun_q, overrun_d;
   logic [7:0]  vdata_q, vdata_d;
   logic        vvalid_q, vvalid_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        wr_ack_q, wr_ack_d;

   logic        fs_fall, hs_fall, da_rise;
   logic        rise_ok, fetch_busy, rise_queue, vid_req, cpu_block;
   logic [5:0]  bpr_new;
   logic [3:0]  rep_new;
   logic [15:0] row_next;
   logic        ram_cs, ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        clr_pend, cap_vid, cap_cpu;

   assign fs_fall = fs_p_q & ~fs_s_q;
   assign hs_fall = hs_p_q & ~hs_s_q;
   assign da_rise = da_s_q & ~da_p_q;

   // A fetch counts as outstanding until its byte has been captured, so a
   // strobe arriving during VID_RD/VID_CAP is an overrun rather than a new fetch.
   assign fetch_busy = vid_pend_q || (state_q == VID_RD) || (state_q == VID_CAP);
   assign rise_ok    = da_rise && (byte_cnt_q < bpr_q);
   assign rise_queue = rise_ok && !fetch_busy;
   assign vid_req    = !fs_fall && (vid_pend_q || rise_queue);
   assign cpu_block  = cpu_ack_q || wr_ack_q;

   always_comb begin
      bpr_new = 6'd32;
      rep_new = 4'd12;
      if (bus.AnG) begin
         case (bus.GM)
            3'b000, 3'b001: begin bpr_new = 6'd16; rep_new = 4'd3; end
            3'b010:         begin bpr_new = 6'd32; rep_new = 4'd3; end
            3'b011:         begin bpr_new = 6'd16; rep_new = 4'd2; end
            3'b100:         begin bpr_new = 6'd32; rep_new = 4'd2; end
            3'b101:         begin bpr_new = 6'd16; rep_new = 4'd1; end
            default:        begin bpr_new = 6'd32; rep_new = 4'd1; end
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = 16'h0000;
      ram_wdata = 8'h00;
      clr_pend  = 1'b0;
      cap_vid   = 1'b0;
      cap_cpu   = 1'b0;
      case (state_q)
         IDLE: begin
            if (vid_req)
               state_d = VID_RD;
            else if (bus.CpuReq && !cpu_block)
               state_d = bus.CpuWe ? CPU_WR : CPU_RD;
         end
         VID_RD: begin
            ram_cs   = 1'b1;
            ram_addr = vid_addr_q;
            clr_pend = 1'b1;
            state_d  = VID_CAP;
         end
         VID_CAP: begin
            cap_vid = 1'b1;
            state_d = IDLE;
         end
         CPU_RD: begin
            ram_cs   = 1'b1;
            ram_addr = bus.CpuAddr;
            state_d  = CPU_CAP;
         end
         CPU_CAP: begin
            cap_cpu = 1'b1;
            state_d = IDLE;
         end
         CPU_WR: begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = bus.CpuAddr;
            ram_wdata = bus.CpuWData;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bpr_d       = bpr_q;
      rep_d       = rep_q;
      row_base_d  = row_base_q;
      vid_addr_d  = vid_addr_q;
      line_cnt_d  = line_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      vid_pend_d  = vid_pend_q;
      overrun_d   = overrun_q;
      vdata_d     = vdata_q;
      vvalid_d    = cap_vid;
      cpu_rdata_d = cpu_rdata_q;
      cpu_ack_d   = cap_cpu || wr_ack_q;
      wr_ack_d    = (state_q == CPU_WR);
      row_next    = row_base_q;

      if (clr_pend)
         vid_pend_d = 1'b0;
      if (rise_queue)
         vid_pend_d = 1'b1;
      if (rise_ok && fetch_busy)
         overrun_d = 1'b1;
      if (cap_vid) begin
         vdata_d    = bus.RamRData;
         vid_addr_d = vid_addr_q + 16'd1;
         byte_cnt_d = byte_cnt_q + 6'd1;
      end
      if (cap_cpu)
         cpu_rdata_d = bus.RamRData;

      if (hs_fall) begin
         bpr_d = bpr_new;
         rep_d = rep_new;
      end

      // Line/frame restarts are evaluated after any same-cycle fetch increment.
      if (fs_fall) begin
         row_base_d = bus.VidBase;
         vid_addr_d = bus.VidBase;
         line_cnt_d = 4'd0;
         byte_cnt_d = 6'd0;
         overrun_d  = 1'b0;
         vid_pend_d = 1'b0;
      end else if (hs_fall && (byte_cnt_d != 6'd0)) begin
         if (line_cnt_q == rep_q - 4'd1) begin
            row_next   = row_base_q + {10'd0, bpr_q};
            line_cnt_d = 4'd0;
         end else begin
            line_cnt_d = line_cnt_q + 4'd1;
         end
         row_base_d = row_next;
         vid_addr_d = row_next;
         byte_cnt_d = 6'd0;
      end
   end

   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         state_q     <= IDLE;
         fs_s_q      <= 1'b1;
         fs_p_q      <= 1'b1;
         hs_s_q      <= 1'b1;
         hs_p_q      <= 1'b1;
         da_s_q      <= 1'b0;
         da_p_q      <= 1'b0;
         bpr_q       <= 6'd32;
         rep_q       <= 4'd12;
         row_base_q  <= 16'h0000;
         vid_addr_q  <= 16'h0000;
         line_cnt_q  <= 4'd0;
         byte_cnt_q  <= 6'd0;
         vid_pend_q  <= 1'b0;
         overrun_q   <= 1'b0;
         vdata_q     <= 8'h00;
         vvalid_q    <= 1'b0;
         cpu_rdata_q <= 8'h00;
         cpu_ack_q   <= 1'b0;
         wr_ack_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fs_s_q      <= bus.FSn;
         fs_p_q      <= fs_s_q;
         hs_s_q      <= bus.HSn;
         hs_p_q      <= hs_s_q;
         da_s_q      <= bus.DA0;
         da_p_q      <= da_s_q;
         bpr_q       <= bpr_d;
         rep_q       <= rep_d;
         row_base_q  <= row_base_d;
         vid_addr_q  <= vid_addr_d;
         line_cnt_q  <= line_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         vid_pend_q  <= vid_pend_d;
         overrun_q   <= overrun_d;
         vdata_q     <= vdata_d;
         vvalid_q    <= vvalid_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         wr_ack_q    <= wr_ack_d;
      end
   end

   assign bus.RamCs    = ram_cs;
   assign bus.RamWe    = ram_we;
   assign bus.RamAddr  = ram_addr;
   assign bus.RamWData = ram_wdata;
   assign bus.CpuAck   = cpu_ack_q;
   assign bus.CpuRData = cpu_rdata_q;
   assign bus.VData    = vdata_q;
   assign bus.VValid   = vvalid_q;
   assign bus.Overrun  = overrun_q;
   assign bus.DbgState = state_q;

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed bench for vram_fetch_arbiter: display address generation, CPU access,
// arbitration priority, overrun and reset abort, with a behavioural synchronous RAM.
module tb_vram_fetch_arbiter;

   logic Clk;
   logic Rstn;
   int   total;
   int   fails;
   logic [7:0] exp_q[$];
   logic [7:0] mem [0:65535];
   logic [7:0] ram_rdata;

   vram_fetch_arbiter_if bus ();

   vram_fetch_arbiter dut (
      .Clk  (Clk),
      .Rstn (Rstn),
      .bus  (bus)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // synchronous RAM model
   always @(posedge Clk) begin
      if (bus.RamCs) begin
         if (bus.RamWe)
            mem[bus.RamAddr] <= bus.RamWData;
         else
            ram_rdata <= mem[bus.RamAddr];
      end
   end
   assign bus.RamRData = ram_rdata;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic fs_pulse();
      @(negedge Clk) bus.FSn = 1'b0;
      repeat (2) @(negedge Clk);
      bus.FSn = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic hs_pulse();
      @(negedge Clk) bus.HSn = 1'b0;
      repeat (2) @(negedge Clk);
      bus.HSn = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic strobe(input logic exp_v, input logic [15:0] addr);
      int nv;
      int pos;
      logic [7:0] d;
      nv = 0;
      pos = 0;
      d = 8'h00;
      if (exp_v) exp_q.push_back(pat(addr));
      @(negedge Clk) bus.DA0 = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge Clk);
         if (i == 3) bus.DA0 = 1'b0;
         if (bus.VValid) begin
            nv++;
            pos = i;
            d = bus.VData;
         end
      end
      check("vvalid_count", nv, {31'd0, exp_v});
      if (exp_v) begin
         check("vdata", {24'd0, d}, {24'd0, exp_q.pop_front()});
         check("vvalid_latency", pos, 4);
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] wd);
      int lat;
      lat = 0;
      @(negedge Clk);
      bus.CpuReq = 1'b1; bus.CpuWe = 1'b1; bus.CpuAddr = a; bus.CpuWData = wd;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge Clk);
         if (i == 1)
            check("wr_ram_bus", {6'd0, bus.RamCs, bus.RamWe, bus.RamAddr, bus.RamWData},
                  {6'd0, 1'b1, 1'b1, a, wd});
         if (bus.CpuAck) begin
            lat = i;
            bus.CpuReq = 1'b0;
         end
      end
      bus.CpuReq = 1'b0;
      check("wr_ack_latency", lat, 3);
      @(negedge Clk);
      check("wr_ack_one_cycle", {31'd0, bus.CpuAck}, 0);
   endtask

   task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp_d);
      int lat;
      logic [7:0] d;
      lat = 0;
      d = 8'h00;
      @(negedge Clk);
      bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = a;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge Clk);
         if (i == 1)
            check("rd_ram_bus", {14'd0, bus.RamCs, bus.RamWe, bus.RamAddr}, {14'd0, 1'b1, 1'b0, a});
         if (bus.CpuAck) begin
            lat = i;
            d = bus.CpuRData;
            bus.CpuReq = 1'b0;
         end
      end
      bus.CpuReq = 1'b0;
      check("rd_ack_latency", lat, 3);
      check("rd_data", {24'd0, d}, {24'd0, exp_d});
      @(negedge Clk);
      check("rd_ack_one_cycle", {31'd0, bus.CpuAck}, 0);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nv, vpos, apos;
      logic [7:0] vd, rd;
      total = 0;
      fails = 0;
      bus.FSn = 1'b1; bus.HSn = 1'b1; bus.DA0 = 1'b0; bus.AnG = 1'b0; bus.GM = 3'b000;
      bus.VidBase = 16'h0000; bus.CpuReq = 1'b0; bus.CpuWe = 1'b0;
      bus.CpuAddr = 16'h0000; bus.CpuWData = 8'h00;
      for (int i = 0; i < 65536; i++) begin
         logic [15:0] a;
         a = i[15:0];
         mem[i] = pat(a);
      end
      Rstn = 1'b0;
      repeat (3) @(negedge Clk);

      // reset state
      check("rst_cpu", {23'd0, bus.CpuAck, bus.CpuRData}, 0);
      check("rst_ram", {6'd0, bus.RamCs, bus.RamWe, bus.RamAddr, bus.RamWData}, 0);
      check("rst_video", {22'd0, bus.VData, bus.VValid, bus.Overrun}, 0);
      check("rst_state", {29'd0, bus.DbgState}, 0);
      Rstn = 1'b1;

      // alpha frame: 12 lines share row 0x0400, line 12 starts at 0x0420
      bus.VidBase = 16'h0400;
      fs_pulse();
      for (int ln = 0; ln < 12; ln++) begin
         for (int b = 0; b < 32; b++) strobe(1'b1, 16'h0400 + 16'(b));
         hs_pulse();
      end
      for (int b = 0; b < 4; b++) strobe(1'b1, 16'h0420 + 16'(b));
      check("alpha_no_overrun", {31'd0, bus.Overrun}, 0);

      // GM=101: 16 bytes per row, row advances every line, 17th strobe ignored
      bus.AnG = 1'b1;
      bus.GM = 3'b101;
      fs_pulse();
      hs_pulse();
      for (int ln = 0; ln < 3; ln++) begin
         for (int b = 0; b < 16; b++) strobe(1'b1, 16'h0400 + 16'(ln * 16 + b));
         strobe(1'b0, 16'h0000);
         hs_pulse();
      end
      check("gm_no_overrun", {31'd0, bus.Overrun}, 0);

      // CPU write then read-back, plus top-of-memory and untouched location
      cpu_write(16'h1234, 8'h5A);
      cpu_read(16'h1234, 8'h5A);
      cpu_write(16'hFFFF, 8'hA5);
      cpu_read(16'hFFFF, 8'hA5);
      cpu_read(16'h0042, pat(16'h0042));

      // DA0 rise detected in the same cycle CpuReq is seen: video first
      nv = 0; vpos = 0; apos = 0; vd = 8'h00; rd = 8'h00;
      @(negedge Clk) bus.DA0 = 1'b1;
      @(negedge Clk);
      bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 16'h1234;
      for (int i = 1; i <= 10; i++) begin
         @(negedge Clk);
         if (i == 2) bus.DA0 = 1'b0;
         if (bus.VValid) begin vpos = i; vd = bus.VData; end
         if (bus.CpuAck && apos == 0) begin apos = i; rd = bus.CpuRData; bus.CpuReq = 1'b0; end
      end
      bus.CpuReq = 1'b0;
      check("prio_vvalid_pos", vpos, 3);
      check("prio_vdata", {24'd0, vd}, {24'd0, pat(16'h0430)});
      check("prio_ack_pos", apos, 6);
      check("prio_rdata", {24'd0, rd}, 32'h5A);

      // two DA0 rises two cycles apart
      check("pre_overrun", {31'd0, bus.Overrun}, 0);
      @(negedge Clk) bus.DA0 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge Clk);
         if (i == 1 || i == 3) bus.DA0 = 1'b0;
         if (i == 2) bus.DA0 = 1'b1;
         if (bus.VValid) begin nv++; vd = bus.VData; end
      end
      check("ovr_vvalid_count", nv, 1);
      check("ovr_vdata", {24'd0, vd}, {24'd0, pat(16'h0431)});
      check("ovr_flag", {31'd0, bus.Overrun}, 1);
      fs_pulse();
      check("ovr_cleared_by_fs", {31'd0, bus.Overrun}, 0);

      // reset during CPU_RD aborts it; held request completes afterwards
      apos = 0; rd = 8'h00;
      @(negedge Clk);
      bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 16'h1234;
      @(negedge Clk);
      check("abort_in_cpu_rd", {29'd0, bus.DbgState}, 3);
      Rstn = 1'b0;
      #1;
      check("abort_ram", {6'd0, bus.RamCs, bus.RamWe, bus.RamAddr, bus.RamWData}, 0);
      check("abort_outs", {14'd0, bus.CpuAck, bus.CpuRData, bus.VData, bus.VValid, bus.Overrun}, 0);
      check("abort_state", {29'd0, bus.DbgState}, 0);
      repeat (2) begin
         @(negedge Clk);
         check("abort_no_ack", {31'd0, bus.CpuAck}, 0);
      end
      Rstn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge Clk);
         if (bus.CpuAck && apos == 0) begin apos = i; rd = bus.CpuRData; bus.CpuReq = 1'b0; end
      end
      bus.CpuReq = 1'b0;
      check("post_rst_ack_pos", apos, 3);
      check("post_rst_rdata", {24'd0, rd}, 32'h5A);

      // final report
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
